// File: rtl/event_xing_feeder.sv
// event_xing_feeder: source-side event queue that meters events into a clock-domain crossing
//   Counts incoming event pulses and issues them one at a time as single-cycle
//   pulses whenever the crossing is ready, with an optional post-issue holdoff.
//   Ports:
//     iclk, ireset_n  clock, asynchronous active-low reset
//     ievent          one event per high cycle
//     oready          crossing ready to accept an event
//     oevent          issued event pulse (combinational from oready)
//     pending         queued, not-yet-issued events (registered)
//     idle            nothing queued and no holdoff in progress (registered)
//     overflow        sticky drop flag, cleared by clear_ovf
//     clear_ovf       synchronous clear of overflow / drop_count
//     drop_count      16-bit saturating drop counter, only with EVENT_FEEDER_DROP_CNT_EN
//   Optional feature macro: EVENT_FEEDER_DROP_CNT_EN
module event_xing_feeder #(
  parameter int CNT_W   = 8,
  parameter int MIN_GAP = 0
) (
  input  logic             iclk,
  input  logic             ireset_n,
  input  logic             ievent,
  input  logic             oready,
  output logic             oevent,
  output logic [CNT_W-1:0] pending,
  output logic             idle,
  output logic             overflow,
`ifdef EVENT_FEEDER_DROP_CNT_EN
  output logic [15:0]      drop_count,
`endif
  input  logic             clear_ovf
);
  typedef enum logic [1:0] {IDLE, ARMED, GAP} state_t;
  localparam bit       HAS_GAP  = MIN_GAP > 0;
  localparam logic [7:0] GAP_INIT = 8'(HAS_GAP ? MIN_GAP - 1 : 0);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic [7:0]       gap_q, gap_d;
  logic             idle_q, idle_d, ovf_q, ovf_d;
  logic             issue, drop;
  assign issue    = (state_q == ARMED) && oready;
  assign oevent   = issue;
  assign pending  = pending_q;
  assign idle     = idle_q;
  assign overflow = ovf_q;
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    // a full counter only drops when no issue frees a slot this cycle
    drop      = ievent && !issue && (&pending_q);
    pending_d = drop ? pending_q : pending_q + CNT_W'(ievent) - CNT_W'(issue);
    case (state_q)
      IDLE:  state_d = (pending_d != '0) ? ARMED : IDLE;
      ARMED: begin
        if (issue && HAS_GAP) begin
          state_d = GAP;
          gap_d   = GAP_INIT;
        end else if (issue) begin
          state_d = (pending_d != '0) ? ARMED : IDLE;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = (pending_d != '0) ? ARMED : IDLE;
        else gap_d = gap_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
    idle_d = (pending_d == '0) && (state_d == IDLE);
    ovf_d  = drop || (ovf_q && !clear_ovf);
  end
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      gap_q     <= '0;
      idle_q    <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      gap_q     <= gap_d;
      idle_q    <= idle_d;
      ovf_q     <= ovf_d;
    end
  end
`ifdef EVENT_FEEDER_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  assign drop_count = drop_cnt_q;
  // increment wins over clear; saturates at all-ones
  assign drop_cnt_d = drop ? drop_cnt_q + 16'((~&drop_cnt_q)) : (clear_ovf ? 16'd0 : drop_cnt_q);
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) drop_cnt_q <= '0;
    else drop_cnt_q <= drop_cnt_d;
  end
`endif
endmodule

// File: tb/tb_event_xing_feeder.sv
// tb_event_xing_feeder: randomized check of event_xing_feeder against a queue-count model
module tb_event_xing_feeder;
  logic       iclk = 1'b0;
  logic       ireset_n = 1'b0;
  logic       ievent = 1'b0;
  logic       oready = 1'b0;
  logic       clear_ovf = 1'b0;
  logic       oev0, idle0, ovf0, oev1, idle1, ovf1;
  logic [7:0] pend0;
  logic [1:0] pend1;
`ifdef EVENT_FEEDER_DROP_CNT_EN
  logic [15:0] dc0, dc1;
`endif
  int checks = 0;
  int errors = 0;
  int cw[2] = '{8, 2};
  int gp[2] = '{0, 3};
  int mp[2], mc[2], mo[2], md[2];
  always #5 iclk = ~iclk;
  event_xing_feeder #(.CNT_W(8), .MIN_GAP(0)) d0 (
    .iclk(iclk), .ireset_n(ireset_n), .ievent(ievent), .oready(oready),
    .oevent(oev0), .pending(pend0), .idle(idle0), .overflow(ovf0),
`ifdef EVENT_FEEDER_DROP_CNT_EN
    .drop_count(dc0),
`endif
    .clear_ovf(clear_ovf));
  event_xing_feeder #(.CNT_W(2), .MIN_GAP(3)) d1 (
    .iclk(iclk), .ireset_n(ireset_n), .ievent(ievent), .oready(oready),
    .oevent(oev1), .pending(pend1), .idle(idle1), .overflow(ovf1),
`ifdef EVENT_FEEDER_DROP_CNT_EN
    .drop_count(dc1),
`endif
    .clear_ovf(clear_ovf));
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask
  function automatic int exp_issue(input int i);
    return (mp[i] > 0 && mc[i] == 0 && oready) ? 1 : 0;
  endfunction
  task automatic check_all();
    check("oevent0", int'(oev0), exp_issue(0));
    check("pending0", int'(pend0), mp[0]);
    check("idle0", int'(idle0), (mp[0] == 0 && mc[0] == 0) ? 1 : 0);
    check("overflow0", int'(ovf0), mo[0]);
    check("oevent1", int'(oev1), exp_issue(1));
    check("pending1", int'(pend1), mp[1]);
    check("idle1", int'(idle1), (mp[1] == 0 && mc[1] == 0) ? 1 : 0);
    check("overflow1", int'(ovf1), mo[1]);
`ifdef EVENT_FEEDER_DROP_CNT_EN
    check("drop_count0", int'(dc0), md[0]);
    check("drop_count1", int'(dc1), md[1]);
`endif
  endtask
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mp[i] = 0; mc[i] = 0; mo[i] = 0; md[i] = 0;
    end
  endtask
  // one clock: drive, compare on the falling edge, then advance the model at the rising edge
  task automatic step(input bit ev, input bit rdy, input bit clr);
    int iss, dr;
    ievent = ev; oready = rdy; clear_ovf = clr;
    @(negedge iclk);
    check_all();
    @(posedge iclk);
    for (int i = 0; i < 2; i++) begin
      iss = exp_issue(i);
      dr = (ev && !iss && mp[i] == (1 << cw[i]) - 1) ? 1 : 0;
      if (!dr) mp[i] = mp[i] + int'(ev) - iss;
      mc[i] = iss ? gp[i] : (mc[i] > 0 ? mc[i] - 1 : 0);
      mo[i] = dr ? 1 : (clr ? 0 : mo[i]);
      md[i] = dr ? (md[i] < 65535 ? md[i] + 1 : 65535) : (clr ? 0 : md[i]);
    end
    #1;
  endtask
  task automatic do_reset();
    ievent = 1'b0; oready = 1'b0; clear_ovf = 1'b0;
    ireset_n = 1'b0;
    model_reset();
    @(negedge iclk);
    ireset_n = 1'b1;
    @(posedge iclk);
    #1;
  endtask
  initial begin
    int ep, rp;
    do_reset();
    @(negedge iclk);
    check_all();
    @(posedge iclk); #1;
    step(1, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    check("burst_pending0", int'(pend0), 5);
    check("burst_pending1", int'(pend1), 3);
    check("sat_overflow1", int'(ovf1), 1);
    step(0, 1, 0);
    step(0, 0, 0);
    check("after_one_issue0", int'(pend0), 4);
    step(1, 1, 0);
    step(1, 1, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    ievent = 1'b0; oready = 1'b1;
    #1;
    check("pre_reset_oevent0", int'(oev0), 1);
    #1;
    ireset_n = 1'b0;
    #1;
    check("async_oevent0", int'(oev0), 0);
    check("async_pending0", int'(pend0), 0);
    check("async_oevent1", int'(oev1), 0);
    check("async_idle1", int'(idle1), 1);
    model_reset();
    @(negedge iclk);
    ireset_n = 1'b1;
    oready = 1'b0;
    @(posedge iclk); #1;
    for (int ph = 0; ph < 8; ph++) begin
      ep = $urandom_range(5, 95);
      rp = $urandom_range(0, 100);
      for (int n = 0; n < 400; n++)
        step($urandom_range(0, 99) < ep, $urandom_range(0, 99) < rp, $urandom_range(0, 99) < 3);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
